// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter (IFU = M0, LSU = M1), one read in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed M1 priority.
module axi_read_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   // master 0 (IFU)
   input  logic [ADDR_W-1:0] i_m0_araddr,
   input  logic [ID_W-1:0]   i_m0_arid,
   input  logic [7:0]        i_m0_arlen,
   input  logic [2:0]        i_m0_arsize,
   input  logic [1:0]        i_m0_arburst,
   input  logic              i_m0_arvalid,
   output logic              o_m0_arready,
   output logic [DATA_W-1:0] o_m0_rdata,
   output logic [1:0]        o_m0_rresp,
   output logic [ID_W-1:0]   o_m0_rid,
   output logic              o_m0_rvalid,
   output logic              o_m0_rlast,
   input  logic              i_m0_rready,
   // master 1 (LSU)
   input  logic [ADDR_W-1:0] i_m1_araddr,
   input  logic [ID_W-1:0]   i_m1_arid,
   input  logic [7:0]        i_m1_arlen,
   input  logic [2:0]        i_m1_arsize,
   input  logic [1:0]        i_m1_arburst,
   input  logic              i_m1_arvalid,
   output logic              o_m1_arready,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic [1:0]        o_m1_rresp,
   output logic [ID_W-1:0]   o_m1_rid,
   output logic              o_m1_rvalid,
   output logic              o_m1_rlast,
   input  logic              i_m1_rready,
   // downstream
   output logic [ADDR_W-1:0] o_s_araddr,
   output logic [ID_W-1:0]   o_s_arid,
   output logic [7:0]        o_s_arlen,
   output logic [2:0]        o_s_arsize,
   output logic [1:0]        o_s_arburst,
   output logic              o_s_arvalid,
   input  logic              i_s_arready,
   input  logic [DATA_W-1:0] i_s_rdata,
   input  logic [1:0]        i_s_rresp,
   input  logic [ID_W-1:0]   i_s_rid,
   input  logic              i_s_rvalid,
   input  logic              i_s_rlast,
   output logic              o_s_rready,
   // status
   output logic              o_busy,
   output logic              o_len_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR0,
      S_R0,
      S_AR1,
      S_R1
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] len_q, len_d;
   logic [7:0] beat_q, beat_d;
   logic       len_err_q, len_err_d;
   logic       grant1;
   logic       r_fire;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // on a tie the master that was not served last wins
   assign grant1 = i_m1_arvalid &&
                   (!i_m0_arvalid || !last_q);
`else
   assign grant1 = i_m1_arvalid;
`endif

   assign r_fire =
      ((state_q == S_R0) && i_s_rvalid && i_m0_rready) ||
      ((state_q == S_R1) && i_s_rvalid && i_m1_rready);

   assign o_busy    = (state_q != S_IDLE);
   assign o_len_err = len_err_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         beat_q    <= '0;
         len_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         len_err_q <= len_err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q    <= last_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      beat_d    = beat_q;
      len_err_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    = last_q;
`endif

      o_m0_arready = 1'b0;
      o_m1_arready = 1'b0;
      o_m0_rdata   = '0;
      o_m0_rresp   = '0;
      o_m0_rid     = '0;
      o_m0_rvalid  = 1'b0;
      o_m0_rlast   = 1'b0;
      o_m1_rdata   = '0;
      o_m1_rresp   = '0;
      o_m1_rid     = '0;
      o_m1_rvalid  = 1'b0;
      o_m1_rlast   = 1'b0;
      o_s_araddr   = '0;
      o_s_arid     = '0;
      o_s_arlen    = '0;
      o_s_arsize   = '0;
      o_s_arburst  = '0;
      o_s_arvalid  = 1'b0;
      o_s_rready   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_m0_arvalid || i_m1_arvalid) begin
               state_d = grant1 ? S_AR1 : S_AR0;
            end
         end
         S_AR0: begin
            o_s_araddr   = i_m0_araddr;
            o_s_arid     = i_m0_arid;
            o_s_arlen    = i_m0_arlen;
            o_s_arsize   = i_m0_arsize;
            o_s_arburst  = i_m0_arburst;
            o_s_arvalid  = i_m0_arvalid;
            o_m0_arready = i_s_arready;
            if (i_m0_arvalid && i_s_arready) begin
               len_d   = i_m0_arlen;
               beat_d  = '0;
               state_d = S_R0;
            end
         end
         S_R0: begin
            o_m0_rdata  = i_s_rdata;
            o_m0_rresp  = i_s_rresp;
            o_m0_rid    = i_s_rid;
            o_m0_rvalid = i_s_rvalid;
            o_m0_rlast  = i_s_rlast;
            o_s_rready  = i_m0_rready;
         end
         S_AR1: begin
            o_s_araddr   = i_m1_araddr;
            o_s_arid     = i_m1_arid;
            o_s_arlen    = i_m1_arlen;
            o_s_arsize   = i_m1_arsize;
            o_s_arburst  = i_m1_arburst;
            o_s_arvalid  = i_m1_arvalid;
            o_m1_arready = i_s_arready;
            if (i_m1_arvalid && i_s_arready) begin
               len_d   = i_m1_arlen;
               beat_d  = '0;
               state_d = S_R1;
            end
         end
         S_R1: begin
            o_m1_rdata  = i_s_rdata;
            o_m1_rresp  = i_s_rresp;
            o_m1_rid    = i_s_rid;
            o_m1_rvalid = i_s_rvalid;
            o_m1_rlast  = i_s_rlast;
            o_s_rready  = i_m1_rready;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // completion follows rlast alone; a count mismatch only flags
      if (r_fire) begin
         beat_d = beat_q + 8'd1;
         if (i_s_rlast) begin
            len_err_d = (beat_q != len_q);
            state_d   = S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    = (state_q == S_R1);
`endif
         end else begin
            len_err_d = (beat_q == len_q);
         end
      end
   end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single upstream AXI4 read port of the core between two read requesters: M0 (IFU instruction fetch) and M1 (LSU load).
- Sits between the IFU/LSU and the address-decoding crossbar. Its S-side drives the crossbar's master read inputs.
- Write channels do not pass through this block. The LSU write port wires straight to the crossbar.
- Supports one outstanding read transaction at a time. A grant is held from AR handshake through the final R beat (rlast).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, AXI ID width.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_m{0,1}_araddr/arid/arlen/arsize/arburst  in  ADDR_W/ID_W/8/3/2  master x AR payload
- i_m{0,1}_arvalid  in  1  master x AR valid
- o_m{0,1}_arready  out  1  master x AR ready
- o_m{0,1}_rdata/rresp/rid  out  DATA_W/2/ID_W  master x R payload
- o_m{0,1}_rvalid, o_m{0,1}_rlast  out  1  master x R valid / last
- i_m{0,1}_rready  in  1  master x R ready
- o_s_araddr/arid/arlen/arsize/arburst  out  ADDR_W/ID_W/8/3/2  downstream AR payload
- o_s_arvalid  out  1  downstream AR valid
- i_s_arready  in  1  downstream AR ready
- i_s_rdata/rresp/rid  in  DATA_W/2/ID_W  downstream R payload
- i_s_rvalid, i_s_rlast  in  1  downstream R valid / last
- o_s_rready  out  1  downstream R ready
- o_busy  out  1  a transaction is in flight (state != IDLE)
- o_len_err  out  1  one-cycle pulse on a beat-count/rlast mismatch

Behaviour:
- Clock and reset: single clock i_clock. Reset i_reset is synchronous and active-high.
- State machine states: IDLE, AR0, R0, AR1, R1.
- Reset values:
  - State = IDLE.
  - All o_*valid, o_*ready, o_*rlast, o_busy and o_len_err = 0.
  - All payload outputs = 0.
  - beat_cnt = 0.
  - last_grant = 1.
- IDLE:
  - All arready/rvalid outputs are 0. o_s_arvalid = 0.
  - If any i_mX_arvalid is high, the registered grant is chosen and the block moves to ARx on the next edge.
  - This gives exactly one cycle of arbitration latency.
  - Simultaneous requests resolve by the policy in Optional Feature.
- ARx:
  - o_s_ar* = i_mX_ar*. o_s_arvalid = i_mX_arvalid. o_mX_arready = i_s_arready.
  - The other master's arready is held at 0.
  - On o_s_arvalid && i_s_arready: latch arlen into len_q, clear beat_cnt, go to Rx.
  - If the master drops arvalid before the handshake (a protocol violation), stay in ARx.
- Rx:
  - o_mX_r* = i_s_r*. o_s_rready = i_mX_rready.
  - The other master's rvalid/rlast are 0.
  - o_s_arvalid = 0, so a second AR is never issued.
  - Each i_s_rvalid && o_s_rready beat increments beat_cnt (8-bit, wraps at 255).
  - A beat with i_s_rlast = 1 returns the state machine to IDLE on the next edge. last_grant is updated to X.
  - If beat_cnt != len_q on the rlast beat, or a beat with beat_cnt == len_q arrives without rlast, o_len_err pulses for one cycle.
  - A len_err pulse does not change sequencing. Completion is taken from rlast only.
- rresp is passed through unmodified. SLVERR/DECERR do not alter arbitration.
- Back-to-back transactions: a new grant may be decided in the IDLE cycle that follows rlast. The minimum gap between consecutive transactions is 1 idle cycle.
- Reset mid-transaction: the block returns to IDLE immediately and drops all valids/readies. Downstream slaves are reset by the same i_reset.
- Requester stability: a non-granted requester holding arvalid keeps seeing arready = 0 until it is granted. It must keep its payload stable per AXI rules.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both masters request in IDLE, the one not equal to last_grant wins. With the reset value last_grant = 1, M0 wins the first tie.
- Undefined: fixed priority, M1 (LSU) always wins ties. last_grant is unused.
- Both modes: a lone request is always granted.

Test Plan:
- Single fetch: M0 arvalid, araddr=0x3000_0000, arlen=0, downstream arready after 2 cycles, one R beat rdata=0xDEADBEEF rlast=1 -> o_m0_rdata=0xDEADBEEF with o_m0_rvalid for 1 beat; o_m1_rvalid stays 0; o_busy high from cycle after request through rlast; state returns to IDLE.
- Simultaneous requests, macro off: M0 and M1 arvalid in the same cycle, 3 repetitions -> all three first grants go to M1; M0 is served after each M1 rlast.
- Simultaneous requests, macro on: same stimulus -> grants alternate M0, M1, M0.
- Burst: M1 arlen=3, 4 beats with rready toggled 1,0,1,1 -> 4 beats delivered in order; no beat lost during the stall; no o_len_err.
- Length mismatch: arlen=1, slave asserts rlast on the first beat -> o_len_err pulses once; return to IDLE; next request is granted normally.
- Reset mid-burst: i_reset asserted during R1 beat 2 of 4 -> next cycle all outputs are 0 and state is IDLE; after reset release, an M0 request completes normally.
